// File: rtl/cap_volt_monitor.sv
// Multi-channel resonant-capacitor voltage monitor: ADC code to signed mV conversion,
// per-channel charge/discharge FSM with debounce, hysteresis and a latched over-voltage fault.
module cap_volt_monitor #(
    parameter int                NCH     = 2,
    parameter int                ADC_W   = 14,
    parameter int                SET_W   = 8,
    parameter logic [NCH*32-1:0] FS_MV   = {32'd10000, 32'd24000},
    parameter int                DEB_CNT = 5,
    parameter int                HYST_MV = 200,
    parameter int                OV_MV   = 1000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NCH*ADC_W-1:0] adc_data,
    input  logic                 adc_vld,
    input  logic [NCH*SET_W-1:0] set_code,
    input  logic [NCH-1:0]       charge_en,
    input  logic [NCH-1:0]       discharge_en,
    input  logic [NCH-1:0]       fault_clr,
    output logic [NCH*32-1:0]    volt_mv,
    output logic                 volt_vld,
    output logic [NCH-1:0]       reached,
    output logic [NCH-1:0]       ov_fault,
    output logic [NCH-1:0]       mode_err,
    output logic [NCH-1:0]       busy
);

    localparam logic [63:0] ADC_MAX = (64'd1 << ADC_W) - 64'd1;
    localparam logic [3:0]  DEB_LIM = 4'(DEB_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_DISCHARGE,
        S_REACHED_C,
        S_REACHED_D,
        S_FAULT
    } state_t;

    logic               r_vld1;
    logic [63:0]        r_num [NCH];
    logic [NCH*32-1:0]  r_volt;
    logic               r_volt_vld;

    state_t             r_state [NCH];
    logic [3:0]         r_deb   [NCH];
    logic [3:0]         r_ovc   [NCH];
    logic [NCH-1:0]     r_reached;
    logic [NCH-1:0]     r_busy;
    logic [NCH-1:0]     r_fault;
    logic [NCH-1:0]     r_mode_err;

    state_t             w_nxt   [NCH];
    logic [63:0]        w_set   [NCH];
    logic signed [63:0] w_tgt   [NCH];
    logic signed [63:0] w_mv    [NCH];
    logic [NCH-1:0]     w_qual;
    logic [NCH-1:0]     w_ovq;
    logic [NCH-1:0]     w_deb_hit;
    logic [NCH-1:0]     w_ov_hit;

    // Two-stage conversion: scale the code by 2*FS, then divide by full-scale code and remove the offset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vld1     <= 1'b0;
            r_volt_vld <= 1'b0;
            r_volt     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_num[i] <= '0;
            end
        end else begin
            r_vld1     <= adc_vld;
            r_volt_vld <= r_vld1;
            for (int i = 0; i < NCH; i++) begin
                if (adc_vld) begin
                    r_num[i] <= 64'(adc_data[i*ADC_W +: ADC_W]) * 64'(FS_MV[i*32 +: 32]) * 64'd2;
                end
                if (r_vld1) begin
                    r_volt[i*32 +: 32] <= 32'((r_num[i] / ADC_MAX) - 64'(FS_MV[i*32 +: 32]));
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_set[i] = 64'(set_code[i*SET_W +: SET_W]);
            if (w_set[i] > 64'd100) begin
                w_set[i] = 64'd100;
            end
            w_tgt[i] = $signed((w_set[i] * 64'(FS_MV[i*32 +: 32])) / 64'd100);
            w_mv[i]  = 64'($signed(r_volt[i*32 +: 32]));

            case (r_state[i])
                S_CHARGE:    w_qual[i] = (w_mv[i] >= w_tgt[i]);
                S_DISCHARGE: w_qual[i] = (w_mv[i] <= w_tgt[i]);
                S_REACHED_C: w_qual[i] = (w_mv[i] < w_tgt[i] - 64'(HYST_MV));
                S_REACHED_D: w_qual[i] = (w_mv[i] > w_tgt[i] + 64'(HYST_MV));
                default:     w_qual[i] = 1'b0;
            endcase
            w_ovq[i]     = (w_mv[i] > w_tgt[i] + 64'(OV_MV));
            w_deb_hit[i] = r_volt_vld && w_qual[i] && (r_deb[i] >= DEB_LIM - 4'd1);
            w_ov_hit[i]  = r_volt_vld && w_ovq[i] && (r_ovc[i] >= DEB_LIM - 4'd1);

            // FAULT only leaves on a clear with an acceptable last sample; otherwise OV wins, then conflicts.
            w_nxt[i] = r_state[i];
            if (r_state[i] == S_FAULT) begin
                if (fault_clr[i] && !w_ovq[i]) begin
                    w_nxt[i] = S_IDLE;
                end
            end else if (w_ov_hit[i]) begin
                w_nxt[i] = S_FAULT;
            end else if (charge_en[i] && discharge_en[i]) begin
                w_nxt[i] = S_IDLE;
            end else begin
                case (r_state[i])
                    S_IDLE: begin
                        if (charge_en[i]) begin
                            w_nxt[i] = S_CHARGE;
                        end else if (discharge_en[i]) begin
                            w_nxt[i] = S_DISCHARGE;
                        end
                    end
                    S_CHARGE: begin
                        if (!charge_en[i]) begin
                            w_nxt[i] = S_IDLE;
                        end else if (w_deb_hit[i]) begin
                            w_nxt[i] = S_REACHED_C;
                        end
                    end
                    S_REACHED_C: begin
                        if (!charge_en[i]) begin
                            w_nxt[i] = S_IDLE;
                        end else if (w_deb_hit[i]) begin
                            w_nxt[i] = S_CHARGE;
                        end
                    end
                    S_DISCHARGE: begin
                        if (!discharge_en[i]) begin
                            w_nxt[i] = S_IDLE;
                        end else if (w_deb_hit[i]) begin
                            w_nxt[i] = S_REACHED_D;
                        end
                    end
                    S_REACHED_D: begin
                        if (!discharge_en[i]) begin
                            w_nxt[i] = S_IDLE;
                        end else if (w_deb_hit[i]) begin
                            w_nxt[i] = S_DISCHARGE;
                        end
                    end
                    default: w_nxt[i] = r_state[i];
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_reached  <= '0;
            r_busy     <= '0;
            r_fault    <= '0;
            r_mode_err <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= S_IDLE;
                r_deb[i]   <= '0;
                r_ovc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_nxt[i];
                if (w_nxt[i] != r_state[i]) begin
                    r_deb[i] <= '0;
                    r_ovc[i] <= '0;
                end else if (r_volt_vld) begin
                    r_deb[i] <= !w_qual[i] ? 4'd0 : (r_deb[i] < DEB_LIM) ? r_deb[i] + 4'd1 : r_deb[i];
                    r_ovc[i] <= !w_ovq[i]  ? 4'd0 : (r_ovc[i] < DEB_LIM) ? r_ovc[i] + 4'd1 : r_ovc[i];
                end
                r_reached[i]  <= (w_nxt[i] == S_REACHED_C) || (w_nxt[i] == S_REACHED_D);
                r_busy[i]     <= (w_nxt[i] == S_CHARGE) || (w_nxt[i] == S_DISCHARGE);
                r_fault[i]    <= (w_nxt[i] == S_FAULT);
                r_mode_err[i] <= charge_en[i] & discharge_en[i];
            end
        end
    end

    assign volt_mv  = r_volt;
    assign volt_vld = r_volt_vld;
    assign reached  = r_reached;
    assign busy     = r_busy;
    assign ov_fault = r_fault;
    assign mode_err = r_mode_err;

endmodule
